// File: rtl/rtc_pkg.sv
// rtc_pkg: write-select encoding and calendar helper functions shared by the RTC files
package rtc_pkg;

    localparam logic [2:0] SEL_SEC  = 3'd0;
    localparam logic [2:0] SEL_MIN  = 3'd1;
    localparam logic [2:0] SEL_HR   = 3'd2;
    localparam logic [2:0] SEL_DAY  = 3'd3;
    localparam logic [2:0] SEL_MON  = 3'd4;
    localparam logic [2:0] SEL_YEAR = 3'd5;
    localparam logic [2:0] SEL_WDAY = 3'd6;

    function automatic logic is_leap(input logic [31:0] yy);
        return ((yy % 32'd4 == 32'd0) && (yy % 32'd100 != 32'd0)) || (yy % 32'd400 == 32'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] mm, input logic [31:0] yy);
        return (mm == 4'd2) ? (is_leap(yy) ? 5'd29 : 5'd28) :
               (mm == 4'd4 || mm == 4'd6 || mm == 4'd9 || mm == 4'd11) ? 5'd30 : 5'd31;
    endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// rtc_calendar_if: field-write port, alarm controls and calendar outputs of the RTC
interface rtc_calendar_if #(
    parameter int YEAR_W = 12
);
    logic              wr_en;
    logic [2:0]        wr_sel;
    logic [YEAR_W-1:0] wr_data;
    logic              wr_err;
    logic              alm_en;
    logic [4:0]        alm_hr;
    logic [5:0]        alm_min;
    logic              alm_clr;
    logic              alarm_irq;
    logic              sec_tick;
    logic [5:0]        sec;
    logic [5:0]        min;
    logic [4:0]        hr;
    logic [4:0]        dd;
    logic [3:0]        mm;
    logic [YEAR_W-1:0] yy;
    logic [2:0]        ww;

    modport master (
        output wr_en, wr_sel, wr_data, alm_en, alm_hr, alm_min, alm_clr,
        input  wr_err, alarm_irq, sec_tick, sec, min, hr, dd, mm, yy, ww
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, alm_en, alm_hr, alm_min, alm_clr,
        output wr_err, alarm_irq, sec_tick, sec, min, hr, dd, mm, yy, ww
    );
endinterface

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk down to a raw one-second tick, re-phasable by clr
module rtc_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // next count: wrap on the last cycle of the second or on a re-phase request
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);

    // count register, synchronous active-low reset
    always_ff @(posedge clk) cnt_q <= !res ? '0 : cnt_d;
endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: real-time clock/calendar with validated field writes and hh:mm alarm
module rtc_calendar
    import rtc_pkg::*;
#(
    parameter int CLK_DIV   = 50_000_000,
    parameter int YEAR_W    = 12,
    parameter int BASE_YEAR = 2016,
    parameter int BASE_WDAY = 5
) (
    input logic         clk,
    input logic         res,
    rtc_calendar_if.slave bus
);
    localparam logic [YEAR_W-1:0] BASE_YY = YEAR_W'(BASE_YEAR);
    localparam logic [2:0]        BASE_WW = 3'(BASE_WDAY);

    logic [5:0]        sec_q, sec_d, min_q, min_d, t_sec, t_min;
    logic [4:0]        hr_q, hr_d, dd_q, dd_d, t_hr, t_dd;
    logic [3:0]        mm_q, mm_d, t_mm;
    logic [YEAR_W-1:0] yy_q, yy_d, t_yy, data;
    logic [2:0]        ww_q, ww_d, t_ww, sel;
    logic              pend_q, pend_d, err_q, err_d, tick_q, tick_d, irq_q, irq_d;
    logic [4:0]        dim_cur, dim_wm, dim_wy;
    logic              raw, do_tick, wr_ok, sec_wr, c_min, c_hr, c_day, c_mon, c_yr;

    rtc_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
        .clk  (clk),
        .res  (res),
        .clr  (sec_wr),
        .tick (raw)
    );

    // validate writes, ripple the one-second carry chain, and pick tick vs. write update
    always_comb begin
        data    = bus.wr_data;
        sel     = bus.wr_sel;
        dim_cur = days_in_month(mm_q, 32'(yy_q));
        dim_wm  = days_in_month(data[3:0], 32'(yy_q));
        dim_wy  = days_in_month(mm_q, 32'(data));
        wr_ok   = bus.wr_en && (
                  (sel == SEL_SEC || sel == SEL_MIN) ? (data < YEAR_W'(60)) :
                  (sel == SEL_HR)   ? (data < YEAR_W'(24)) :
                  (sel == SEL_DAY)  ? (data >= YEAR_W'(1) && data <= YEAR_W'(dim_cur)) :
                  (sel == SEL_MON)  ? (data >= YEAR_W'(1) && data <= YEAR_W'(12)) :
                  (sel == SEL_YEAR) ? 1'b1 :
                  (sel == SEL_WDAY) ? (data < YEAR_W'(7)) : 1'b0);
        sec_wr  = wr_ok && sel == SEL_SEC;
        // a tick that lands on a write cycle waits one cycle; a seconds write discards it
        do_tick = !bus.wr_en && (raw || pend_q);
        pend_d  = bus.wr_en && (raw || pend_q) && !sec_wr;
        c_min   = sec_q == 6'd59;
        c_hr    = c_min && min_q == 6'd59;
        c_day   = c_hr && hr_q == 5'd23;
        c_mon   = c_day && dd_q == dim_cur;
        c_yr    = c_mon && mm_q == 4'd12;
        t_sec   = c_min ? 6'd0 : sec_q + 6'd1;
        t_min   = !c_min ? min_q : c_hr ? 6'd0 : min_q + 6'd1;
        t_hr    = !c_hr ? hr_q : c_day ? 5'd0 : hr_q + 5'd1;
        t_ww    = !c_day ? ww_q : (ww_q == 3'd6) ? 3'd0 : ww_q + 3'd1;
        t_dd    = !c_day ? dd_q : c_mon ? 5'd1 : dd_q + 5'd1;
        t_mm    = !c_mon ? mm_q : c_yr ? 4'd1 : mm_q + 4'd1;
        t_yy    = !c_yr ? yy_q : (yy_q == '1) ? BASE_YY : yy_q + YEAR_W'(1);
        sec_d   = do_tick ? t_sec : sec_wr ? data[5:0] : sec_q;
        min_d   = do_tick ? t_min : (wr_ok && sel == SEL_MIN) ? data[5:0] : min_q;
        hr_d    = do_tick ? t_hr : (wr_ok && sel == SEL_HR) ? data[4:0] : hr_q;
        ww_d    = do_tick ? t_ww : (wr_ok && sel == SEL_WDAY) ? data[2:0] : ww_q;
        mm_d    = do_tick ? t_mm : (wr_ok && sel == SEL_MON) ? data[3:0] : mm_q;
        yy_d    = do_tick ? t_yy : (wr_ok && sel == SEL_YEAR) ? data : yy_q;
        // month or year writes pull the day back inside the new month length
        dd_d    = do_tick ? t_dd :
                  (wr_ok && sel == SEL_DAY)  ? data[4:0] :
                  (wr_ok && sel == SEL_MON)  ? ((dd_q > dim_wm) ? dim_wm : dd_q) :
                  (wr_ok && sel == SEL_YEAR) ? ((dd_q > dim_wy) ? dim_wy : dd_q) : dd_q;
        err_d   = bus.wr_en && !wr_ok;
        tick_d  = do_tick;
        // only a counted second can raise the alarm; a new match beats a same-cycle clear
        irq_d   = (do_tick && bus.alm_en && t_hr == bus.alm_hr && t_min == bus.alm_min
                   && t_sec == 6'd0) || (irq_q && !bus.alm_clr);
    end

    // calendar, pending-tick and flag registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= '0;
            dd_q   <= 5'd1;
            mm_q   <= 4'd1;
            yy_q   <= BASE_YY;
            ww_q   <= BASE_WW;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            dd_q   <= dd_d;
            mm_q   <= mm_d;
            yy_q   <= yy_d;
            ww_q   <= ww_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            tick_q <= tick_d;
            irq_q  <= irq_d;
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hr        = hr_q;
    assign bus.dd        = dd_q;
    assign bus.mm        = mm_q;
    assign bus.yy        = yy_q;
    assign bus.ww        = ww_q;
    assign bus.wr_err    = err_q;
    assign bus.sec_tick  = tick_q;
    assign bus.alarm_irq = irq_q;
endmodule
